// File: rtl/parity_stream.sv
// Two-stage valid/ready parity generator and checker with a saturating error counter.
// S1 captures the word plus per-byte partial parities; S2 holds the reduced parity and the error flag.
module parity_stream #(
    parameter int WIDTH = 32,
    parameter bit ODD   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             check_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    localparam int NLANES = (WIDTH + 7) / 8;

    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_data_q;
    logic              s1_par_in_q;
    logic              s1_chk_q;
    logic [NLANES-1:0] s1_lanes_q;
    logic [NLANES-1:0] lane_par_d;

    logic              s2_valid_q;
    logic [WIDTH-1:0]  s2_data_q;
    logic              s2_par_q;
    logic              s2_err_q;
    logic              s2_par_d;
    logic              s2_err_d;

    logic [CNT_W-1:0]  err_count_q;
    logic              err_sticky_q;

    logic s1_load;
    logic s2_load;
    logic out_fire;

    // Each lane covers one byte; the top lane is narrower when WIDTH is not a multiple of 8.
    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            localparam int LO = gi * 8;
            localparam int HI = (LO + 8 > WIDTH) ? WIDTH - 1 : LO + 7;
            assign lane_par_d[gi] = ^in_data[HI:LO];
        end
    endgenerate

    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load & ~rst;
    assign out_fire = s2_valid_q & out_ready;

    assign s2_par_d = (^s1_lanes_q) ^ ODD;
    assign s2_err_d = s1_chk_q & (s1_par_in_q != s2_par_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_par_in_q <= 1'b0;
            s1_chk_q    <= 1'b0;
            s1_lanes_q  <= '0;
        end else if (s1_load) begin
            s1_valid_q  <= in_valid;
            s1_data_q   <= in_data;
            s1_par_in_q <= in_par;
            s1_chk_q    <= check_en;
            s1_lanes_q  <= lane_par_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_par_q   <= 1'b0;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s1_data_q;
            s2_par_q   <= s2_par_d;
            s2_err_q   <= s2_err_d;
        end
    end

    // Clear wins over a coincident error delivery; the word still carries out_err.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else if (out_fire && s2_err_q) begin
            err_sticky_q <= 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_par    = s2_par_q;
    assign out_err    = s2_err_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_stream.sv
// Scoreboard bench: A is 32-bit odd parity with a 2-bit counter, B is 13-bit even parity.
module tb_parity_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_par, a_check_en;
    logic        a_out_valid, a_out_ready, a_out_par, a_out_err;
    logic        a_clr_err, a_err_sticky;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_err_count;

    logic        b_in_valid, b_in_ready, b_in_par, b_check_en;
    logic        b_out_valid, b_out_ready, b_out_par, b_out_err;
    logic        b_clr_err, b_err_sticky;
    logic [12:0] b_in_data, b_out_data;
    logic [15:0] b_err_count;

    parity_stream #(.WIDTH(32), .ODD(1'b1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_par(a_in_par), .check_en(a_check_en),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_par(a_out_par), .out_err(a_out_err),
        .clr_err(a_clr_err), .err_count(a_err_count), .err_sticky(a_err_sticky)
    );

    parity_stream #(.WIDTH(13), .ODD(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_par(b_in_par), .check_en(b_check_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_par(b_out_par), .out_err(b_out_err),
        .clr_err(b_clr_err), .err_count(b_err_count), .err_sticky(b_err_sticky)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        p;
        logic        e;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic par_a(input logic [31:0] d);
        return ~^d;
    endfunction

    function automatic logic par_b(input logic [12:0] d);
        return ^d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor for A: counter model, hold-stability, scoreboard pop/push
    logic [1:0]  ea_cnt    = '0;
    logic        ea_sticky = 1'b0;
    logic        a_hold    = 1'b0;
    logic [33:0] a_prev    = '0;
    always @(negedge clk) begin
        exp_t e;
        logic fire_err;
        fire_err = 1'b0;
        check("a_err_count", a_err_count, ea_cnt);
        check("a_err_sticky", a_err_sticky, ea_sticky);
        if (a_hold) begin
            check("a_hold_valid", a_out_valid, 1);
            check("a_hold_word", {a_out_data, a_out_par, a_out_err}, a_prev);
        end
        if (rst) begin
            qa.delete();
            ea_cnt    = '0;
            ea_sticky = 1'b0;
            a_hold    = 1'b0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    check("a_spurious_out", {a_out_valid, a_out_data}, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_out_data", a_out_data, e.d);
                    check("a_out_par", a_out_par, e.p);
                    check("a_out_err", a_out_err, e.e);
                    fire_err = e.e;
                end
            end
            if (a_clr_err) begin
                ea_cnt    = '0;
                ea_sticky = 1'b0;
            end else if (fire_err) begin
                ea_sticky = 1'b1;
                if (ea_cnt != 2'b11) ea_cnt = ea_cnt + 2'd1;
            end
            if (a_in_valid && a_in_ready) begin
                e.d = a_in_data;
                e.p = par_a(a_in_data);
                e.e = a_check_en & (a_in_par != e.p);
                qa.push_back(e);
            end
            a_hold = a_out_valid && !a_out_ready;
            a_prev = {a_out_data, a_out_par, a_out_err};
        end
    end

    // Monitor for B
    logic [15:0] eb_cnt = '0;
    always @(negedge clk) begin
        exp_t e;
        check("b_err_count", b_err_count, eb_cnt);
        if (rst) begin
            qb.delete();
            eb_cnt = '0;
        end else begin
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    check("b_spurious_out", {b_out_valid, b_out_data}, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_out_data", b_out_data, e.d[12:0]);
                    check("b_out_par", b_out_par, e.p);
                    check("b_out_err", b_out_err, e.e);
                    if (e.e) eb_cnt = eb_cnt + 16'd1;
                end
            end
            if (b_in_valid && b_in_ready) begin
                e.d = {19'd0, b_in_data};
                e.p = par_b(b_in_data);
                e.e = b_check_en & (b_in_par != e.p);
                qb.push_back(e);
            end
        end
    end

    // mode 0: always ready, 1: random backpressure, 2: out_ready low for cycles 3-6
    task automatic a_stream(input int n, input int mode, output bit saw_stall);
        int   sent = 0;
        int   cyc  = 0;
        logic acc;
        saw_stall  = 1'b0;
        a_in_data  = $urandom;
        a_in_par   = 1'($urandom_range(0, 1));
        a_check_en = 1'($urandom_range(0, 1));
        a_in_valid = 1'b1;
        while (sent < n && cyc < 1000) begin
            case (mode)
                1:       a_out_ready = ($urandom_range(0, 3) != 0);
                2:       a_out_ready = !(cyc >= 3 && cyc <= 6);
                default: a_out_ready = 1'b1;
            endcase
            #1;
            acc = a_in_ready;
            if (!acc) saw_stall = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                a_in_data  = $urandom;
                a_in_par   = 1'($urandom_range(0, 1));
                a_check_en = 1'($urandom_range(0, 1));
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        if (cyc >= 1000) check("a_stream_timeout", sent, n);
    endtask

    task automatic drain;
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
            tick;
            k++;
        end
        check("drain_a_empty", qa.size(), 0);
        check("drain_b_empty", qb.size(), 0);
    endtask

    // Deliver one word with out_ready held high; returns just after its output transfer edge.
    task automatic a_one(input logic [31:0] d, input logic p, input logic c);
        a_in_data   = d;
        a_in_par    = p;
        a_check_en  = c;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          stall;
        logic [31:0] d;
        int          sat_exp[5] = '{1, 2, 3, 3, 3};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_par = 0; a_check_en = 0; a_out_ready = 0; a_clr_err = 0;
        b_in_valid = 0; b_in_data = 0; b_in_par = 0; b_check_en = 0; b_out_ready = 0; b_clr_err = 0;
        repeat (3) tick;
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_par", a_out_par, 0);
        check("rst_out_err", a_out_err, 0);
        check("rst_err_count", a_err_count, 0);
        check("rst_err_sticky", a_err_sticky, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", a_in_ready, 1);

        // Two-cycle latency on a plain word
        a_out_ready = 1'b1;
        a_in_data = 32'h0000_0001; a_in_par = 0; a_check_en = 0; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        check("lat1_out_valid", a_out_valid, 0);
        tick;
        check("lat2_out_valid", a_out_valid, 1);
        check("lat2_out_data", a_out_data, 32'h0000_0001);
        check("lat2_out_par", a_out_par, 0);
        check("lat2_out_err", a_out_err, 0);
        tick;

        // All-ones word with wrong parity
        a_in_data = 32'hFFFF_FFFF; a_in_par = 0; a_check_en = 1; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick;
        check("ones_out_par", a_out_par, 1);
        check("ones_out_err", a_out_err, 1);
        check("ones_cnt_before", a_err_count, 0);
        tick;
        check("ones_cnt_after", a_err_count, 1);
        check("ones_sticky_after", a_err_sticky, 1);

        a_stream(40, 1, stall);
        drain;

        a_stream(8, 2, stall);
        check("bp_in_ready_low", stall, 1);
        drain;

        // Saturation of the 2-bit counter, then clear coinciding with an error delivery
        a_clr_err = 1'b1;
        tick;
        a_clr_err = 1'b0;
        check("clr_cnt", a_err_count, 0);
        check("clr_sticky", a_err_sticky, 0);
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            a_one(d, ~par_a(d), 1'b1);
            check("sat_cnt", a_err_count, sat_exp[i]);
        end
        d = $urandom;
        a_in_data = d; a_in_par = ~par_a(d); a_check_en = 1; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        tick;
        check("clr_hit_valid", a_out_valid, 1);
        check("clr_hit_err", a_out_err, 1);
        a_clr_err = 1'b1;
        tick;
        a_clr_err = 1'b0;
        check("clr_hit_cnt", a_err_count, 0);
        check("clr_hit_sticky", a_err_sticky, 0);

        // Reset with both stages full under backpressure
        d = $urandom;
        a_one(d, ~par_a(d), 1'b1);
        check("pre_rst_cnt", a_err_count, 1);
        a_out_ready = 1'b0;
        a_in_data = $urandom; a_in_par = 0; a_check_en = 1; a_in_valid = 1'b1;
        tick;
        a_in_data = $urandom;
        tick;
        a_in_valid = 1'b0;
        check("full_in_ready", a_in_ready, 0);
        check("full_out_valid", a_out_valid, 1);
        rst = 1'b1;
        tick;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_cnt", a_err_count, 0);
        check("midrst_in_ready", a_in_ready, 0);
        rst = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) begin
            tick;
            check("no_stale_out", a_out_valid, 0);
        end

        // 13-bit even parity, partial top lane
        b_out_ready = 1'b1;
        b_in_data = 13'h1FFF; b_in_par = 1; b_check_en = 1; b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        tick;
        check("b13_out_valid", b_out_valid, 1);
        check("b13_out_par", b_out_par, 1);
        check("b13_out_err", b_out_err, 0);
        tick;
        b_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_in_data  = 13'($urandom);
            b_in_par   = 1'($urandom_range(0, 1));
            b_check_en = 1'($urandom_range(0, 1));
            tick;
        end
        b_in_valid = 1'b0;
        drain;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; legal range 1..256.
REQ-002 Parameter ODD, default 1: selects parity mode; 1 = odd parity (generated bit = XNOR-reduce of data), 0 = even parity (XOR-reduce).
REQ-003 Parameter CNT_W, default 16: width of the error counter.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: upstream word present.
REQ-007 Port in_ready, output, 1: block can accept a word this cycle.
REQ-008 Port in_data, input, WIDTH: data word.
REQ-009 Port in_par, input, 1: received parity bit accompanying in_data.
REQ-010 Port check_en, input, 1: sampled with the word; 1 = compare in_par against the generated parity.
REQ-011 Port out_valid, output, 1: result word present.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port out_data, output, WIDTH: in_data, passed through unchanged.
REQ-014 Port out_par, output, 1: generated parity for out_data.
REQ-015 Port out_err, output, 1: mismatch for this word; 0 when check_en was 0.
REQ-016 Port clr_err, input, 1: single-cycle request to clear err_count and err_sticky.
REQ-017 Port err_count, output, CNT_W: saturating count of delivered erroneous words.
REQ-018 Port err_sticky, output, 1: set by any delivered error; held until clr_err or rst.

Function
REQ-019 A word transfers in when in_valid and in_ready are both 1; a word transfers out when out_valid and out_ready are both 1.
REQ-020 Pipeline is two register stages: S1 holds the word, in_par, check_en and per-byte partial parities (last lane holds WIDTH mod 8 bits when nonzero); S2 holds the reduced parity, out_data and out_err.
REQ-021 Latency from input transfer to out_valid is exactly 2 cycles with no backpressure; sustained throughput is 1 word per cycle.
REQ-022 S2 loads when it is empty or out_ready is 1; S1 loads when it is empty or S2 loads; in_ready equals the S1 load condition and is combinational from out_ready.
REQ-023 Under backpressure, no word is dropped, duplicated or reordered; out_data, out_par and out_err hold stable while out_valid=1 and out_ready=0.
REQ-024 out_par equals ^data when ODD=0 and ~^data when ODD=1; for WIDTH=1 it is the bit itself or its inverse.
REQ-025 out_err equals check_en AND (in_par != generated parity), evaluated on the word's own sampled values.
REQ-026 err_count increments by 1 on each output transfer with out_err=1; it saturates at 2^CNT_W-1 and does not wrap.
REQ-027 err_sticky sets on the same output transfer that increments err_count.
REQ-028 clr_err has priority: if clr_err coincides with an erroring output transfer, err_count becomes 0 and err_sticky becomes 0; that error is still reported on out_err.
REQ-029 err_count and err_sticky update one cycle after the triggering transfer edge, i.e. they are registered.

Reset
REQ-030 When rst=1 at a clock edge: S1 and S2 are emptied, out_valid=0, out_data=0, out_par=0, out_err=0, err_count=0, err_sticky=0.
REQ-031 During rst, in_ready reads 0; it reads 1 on the first cycle after rst deasserts.
REQ-032 Words in flight when reset asserts mid-operation are discarded, with no output transfer and no count.

Verification
REQ-033 With WIDTH=32, ODD=1, out_ready=1, send 32'h0000_0001, check_en=0 -> out_valid is 1 two cycles later, out_data=32'h0000_0001, out_par=0, out_err=0.
REQ-034 With ODD=1, send 32'hFFFF_FFFF, in_par=0, check_en=1 -> out_par=1, out_err=1, err_count=1 and err_sticky=1 one cycle after the output transfer.
REQ-035 Stream 8 back-to-back words, holding out_ready=0 for cycles 3-6 -> in_ready=0 once both stages are full; all 8 words emerge in order with correct parity and none is lost.
REQ-036 With CNT_W=2, deliver 5 erroring words -> err_count reads 1, 2, 3, 3, 3; then pulse clr_err together with a 6th erroring transfer -> err_count=0, err_sticky=0, and out_err=1 on that word.
REQ-037 Assert rst with both stages full and out_ready=0 -> next cycle out_valid=0 and err_count=0, and no stale word appears after release.
REQ-038 With WIDTH=13, ODD=0, send 13'h1FFF, in_par=1, check_en=1 -> out_par=1 and out_err=0, exercising the partial last lane.
